// File: rtl/dense_input_loader_pkg.sv
// Shared types for the dense-layer input loader: activation format and loader FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dense_input_loader_pkg;

    // Q(INTEGER_WIDTH).(FRACTION_WIDTH) signed fixed-point activation.
    localparam int INTEGER_WIDTH  = 8;
    localparam int FRACTION_WIDTH = 8;

    typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] activation_type;

    typedef enum logic [1:0] {
        LOAD,   // accepting elements of a frame
        DROP,   // discarding the tail of an over-long frame
        FIRE,   // one-cycle start pulse to the layer
        WAIT    // frame frozen until the layer completes
    } loader_state_t;

    // Element counter width; a one-element frame still needs a 1-bit counter.
    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dense_input_loader.sv
// Assembles a stream of activations into a NUM_INPUTS-wide frame and starts a dense layer on it.
// Latency: inputs_ready pulses the cycle after the final element; WAIT exits the cycle after an outputs_ready rise.
// Backpressure: in_ready is 1 in LOAD/DROP, 0 in FIRE/WAIT and while reset is high; one element per cycle when ready.
//
// Ports:
//   clock, reset                 - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready            - element handshake; in_data is one activation, in_last ends a frame
//   inputs                       - assembled frame, held stable from the start pulse until the next load
//   inputs_ready                 - one-cycle start pulse to the layer
//   outputs_ready                - layer completion level; only its rising edge releases the loader
//   frame_error                  - one-cycle pulse (cycle after the offending transfer) on a length mismatch
//   busy                         - high whenever the loader is not in LOAD
module dense_input_loader
    import dense_input_loader_pkg::*;
#(
    parameter int NUM_INPUTS = 16
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  activation_type in_data,
    input  logic           in_last,
    output activation_type inputs [NUM_INPUTS],
    output logic           inputs_ready,
    input  logic           outputs_ready,
    output logic           frame_error,
    output logic           busy
);

    localparam int             CW       = count_width(NUM_INPUTS);
    localparam logic [CW-1:0]  LAST_IDX = CW'(NUM_INPUTS - 1);

    loader_state_t state;
    loader_state_t state_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          frame_error_nxt;
    logic          outputs_ready_q;
    logic          xfer;
    logic          release_edge;

    assign xfer = in_valid && in_ready;

    // Only a fresh rise counts: a completion level left high from the
    // previous frame must not release the next one.
    assign release_edge = outputs_ready && !outputs_ready_q;

    // Gated by reset so nothing is accepted or started in the reset cycle.
    assign in_ready     = !reset && ((state == LOAD) || (state == DROP));
    assign inputs_ready = !reset && (state == FIRE);
    assign busy         = (state != LOAD);

    always_comb begin
        state_nxt       = state;
        count_nxt       = count;
        frame_error_nxt = 1'b0;
        case (state)
            LOAD: begin
                if (xfer) begin
                    if (count == LAST_IDX) begin
                        count_nxt = '0;
                        if (in_last) begin
                            state_nxt = FIRE;
                        end else begin
                            // Frame overran: report now, then swallow the rest up to in_last.
                            frame_error_nxt = 1'b1;
                            state_nxt       = DROP;
                        end
                    end else if (in_last) begin
                        // Short frame: restart collection, partial data is left as is.
                        frame_error_nxt = 1'b1;
                        count_nxt       = '0;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
            end
            DROP: begin
                if (xfer && in_last) begin
                    state_nxt = LOAD;
                    count_nxt = '0;
                end
            end
            FIRE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (release_edge) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= LOAD;
            count           <= '0;
            frame_error     <= 1'b0;
            outputs_ready_q <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                inputs[i] <= '0;
            end
        end else begin
            state           <= state_nxt;
            count           <= count_nxt;
            frame_error     <= frame_error_nxt;
            outputs_ready_q <= outputs_ready;
            // Every LOAD transfer lands in its slot, including the one that overruns.
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if ((state == LOAD) && xfer && (count == CW'(i))) begin
                    inputs[i] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dense_input_loader.sv
module tb_dense_input_loader;
    import dense_input_loader_pkg::*;

    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    activation_type in_data;
    logic           in_last;
    activation_type inputs [N];
    logic           inputs_ready;
    logic           outputs_ready;
    logic           frame_error;
    logic           busy;

    logic           n1_in_valid;
    logic           n1_in_ready;
    activation_type n1_in_data;
    logic           n1_in_last;
    activation_type n1_inputs [1];
    logic           n1_inputs_ready;
    logic           n1_outputs_ready;
    logic           n1_frame_error;
    logic           n1_busy;

    always #5 clock = ~clock;

    dense_input_loader #(.NUM_INPUTS(N)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .inputs(inputs), .inputs_ready(inputs_ready), .outputs_ready(outputs_ready),
        .frame_error(frame_error), .busy(busy)
    );

    dense_input_loader #(.NUM_INPUTS(1)) dut1 (
        .clock(clock), .reset(reset),
        .in_valid(n1_in_valid), .in_ready(n1_in_ready), .in_data(n1_in_data), .in_last(n1_in_last),
        .inputs(n1_inputs), .inputs_ready(n1_inputs_ready), .outputs_ready(n1_outputs_ready),
        .frame_error(n1_frame_error), .busy(n1_busy)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference model state: elements since the last frame boundary, expected frames and errors.
    activation_type seg [$];
    logic [63:0]    exp_q [$];
    int             exp_cyc_q [$];
    int             err_pending = 0;
    int             lens [20];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_frame();
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < N; i++) f[16*i +: 16] = inputs[i];
        return f;
    endfunction

    // Scoreboard monitor: splits the accepted stream at in_last; a segment of exactly N
    // elements must fire one cycle after its last transfer, anything else raises one error
    // (short: on in_last; long: on the N-th element, then the tail is dropped).
    task automatic monitor();
        logic [63:0] exp_f;
        logic [63:0] f;
        int          exp_c;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
                exp_cyc_q.delete();
                err_pending = 0;
                seg.delete();
            end else begin
                if (inputs_ready) begin
                    chk("fire_without_error", frame_error, 0);
                    chk("fire_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        exp_f = exp_q.pop_front();
                        exp_c = exp_cyc_q.pop_front();
                        chk("frame_data", pack_frame(), exp_f);
                        chk("fire_latency", cyc, exp_c);
                    end
                end
                if (frame_error) begin
                    chk("error_expected", err_pending > 0, 1);
                    if (err_pending > 0) err_pending--;
                end
                if (in_valid && in_ready) begin
                    chk("busy_at_transfer", busy, seg.size() >= N);
                    seg.push_back(in_data);
                    if (in_last) begin
                        if (seg.size() == N) begin
                            f = '0;
                            for (int i = 0; i < N; i++) f[16*i +: 16] = seg[i];
                            exp_q.push_back(f);
                            exp_cyc_q.push_back(cyc + 1);
                        end else if (seg.size() < N) begin
                            err_pending++;
                        end
                        seg.delete();
                    end else if (seg.size() == N) begin
                        err_pending++;
                    end
                end
            end
        end
    endtask

    task automatic align();
        @(posedge clock);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the element was accepted.
    task automatic send(input logic [15:0] d, input logic l);
        logic acc;
        int   g;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        g = 0;
        do begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            g++;
        end while (!acc && g < 500);
        chk("send_accepted", acc, 1);
    endtask

    task automatic frame4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
        send(a, 1'b0);
        send(b, 1'b0);
        send(c, 1'b0);
        send(d, 1'b1);
        in_valid = 1'b0;
    endtask

    // Raise outputs_ready one cycle into WAIT; loader must stay blocked until the sampled rise.
    task automatic release_layer();
        @(posedge clock);
        #1 outputs_ready = 1'b1;
        @(negedge clock);
        chk("wait_before_rise", in_ready, 0);
        @(posedge clock);
        #1 outputs_ready = 1'b0;
        @(negedge clock);
        chk("release_in_ready", in_ready, 1);
        chk("release_busy", busy, 0);
    endtask

    task automatic fire_and_release();
        align();
        frame4(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        @(negedge clock);
        chk("fire_after_frame", inputs_ready, 1);
        release_layer();
    endtask

    task automatic drained(input string name);
        chk({name, "_frames_left"}, exp_q.size(), 0);
        chk({name, "_errors_left"}, err_pending, 0);
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_in_ready"}, in_ready, 1);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_inputs_ready"}, inputs_ready, 0);
        chk({name, "_frame_error"}, frame_error, 0);
        chk({name, "_inputs"}, pack_frame(), 64'h0);
    endtask

    // Called at posedge+1: reset for exactly one sampled edge.
    task automatic apply_reset(input string name);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        chk({name, "_in_ready_during"}, in_ready, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk_reset_state(name);
    endtask

    task automatic stream(input int nf);
        for (int f = 0; f < nf; f++) begin
            for (int e = 0; e < lens[f]; e++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    repeat ($urandom_range(1, 4)) @(posedge clock);
                    #1;
                end
                send(16'($urandom), e == lens[f] - 1);
            end
        end
        in_valid = 1'b0;
    endtask

    // Layer model: random 5..30 cycle latency, then a two-cycle completion level.
    task automatic layer_serve(input int nframes);
        logic [63:0] snap;
        int          g;
        for (int f = 0; f < nframes; f++) begin
            g = 0;
            do begin
                @(negedge clock);
                g++;
            end while (!inputs_ready && g < 3000);
            chk("layer_start", inputs_ready, 1);
            snap = pack_frame();
            repeat ($urandom_range(5, 30)) @(posedge clock);
            #1 outputs_ready = 1'b1;
            @(negedge clock);
            chk("layer_wait_in_ready", in_ready, 0);
            chk("layer_inputs_frozen", pack_frame(), snap);
            @(posedge clock);
            @(negedge clock);
            chk("layer_release_in_ready", in_ready, 1);
            @(posedge clock);
            #1 outputs_ready = 1'b0;
        end
    endtask

    task automatic send1(input logic [15:0] d, input logic l);
        @(posedge clock);
        #1;
        n1_in_valid = 1'b1;
        n1_in_data  = d;
        n1_in_last  = l;
        @(negedge clock);
        chk("n1_in_ready", n1_in_ready, 1);
        @(posedge clock);
        #1 n1_in_valid = 1'b0;
    endtask

    initial begin
        int ngood;
        reset            = 1'b1;
        in_valid         = 1'b0;
        in_data          = '0;
        in_last          = 1'b0;
        outputs_ready    = 1'b0;
        n1_in_valid      = 1'b0;
        n1_in_data       = '0;
        n1_in_last       = 1'b0;
        n1_outputs_ready = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("in_ready_in_reset", in_ready, 0);
        chk("n1_in_ready_in_reset", n1_in_ready, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk_reset_state("por");
        chk("n1_por_busy", n1_busy, 0);

        // Nominal Q8.8 frame: 1.0, -2.5, 0.25, 3.0
        align();
        frame4(16'h0100, 16'hFD80, 16'h0040, 16'h0300);
        @(negedge clock);
        chk("nominal_fire", inputs_ready, 1);
        chk("nominal_fire_in_ready", in_ready, 0);
        chk("nominal_values", pack_frame(), 64'h0300_0040_FD80_0100);
        @(negedge clock);
        chk("nominal_pulse_once", inputs_ready, 0);
        chk("nominal_wait_busy", busy, 1);
        chk("nominal_wait_in_ready", in_ready, 0);
        release_layer();
        drained("nominal");

        // Completion level held high across FIRE must not release WAIT
        align();
        outputs_ready = 1'b1;
        frame4(16'h0001, 16'h0002, 16'h8000, 16'h7FFF);
        @(negedge clock);
        chk("held_fire", inputs_ready, 1);
        repeat (3) begin
            @(negedge clock);
            chk("held_level_blocks", in_ready, 0);
        end
        align();
        outputs_ready = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("low_level_blocks", in_ready, 0);
        end
        release_layer();
        fire_and_release();
        drained("wait_release");

        // Short frame
        align();
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b1);
        in_valid = 1'b0;
        @(negedge clock);
        chk("short_error", frame_error, 1);
        chk("short_no_fire", inputs_ready, 0);
        @(negedge clock);
        chk("short_error_once", frame_error, 0);
        fire_and_release();
        drained("short");

        // Long frame: error on the 4th transfer, 5th and 6th dropped
        align();
        send(16'h0A01, 1'b0);
        send(16'h0A02, 1'b0);
        send(16'h0A03, 1'b0);
        send(16'h0A04, 1'b0);
        in_valid = 1'b0;
        @(negedge clock);
        chk("long_error", frame_error, 1);
        chk("long_drop_busy", busy, 1);
        align();
        send(16'h0A05, 1'b0);
        send(16'h0A06, 1'b1);
        in_valid = 1'b0;
        @(negedge clock);
        chk("long_back_to_load", busy, 0);
        chk("long_no_fire", inputs_ready, 0);
        fire_and_release();
        drained("long");

        // Reset in LOAD with two elements collected
        align();
        send(16'h3333, 1'b0);
        send(16'h4444, 1'b0);
        apply_reset("rst_load");
        fire_and_release();
        drained("rst_load");

        // Reset during the FIRE cycle
        align();
        frame4(16'h5151, 16'h5252, 16'h5353, 16'h5454);
        apply_reset("rst_fire");
        @(negedge clock);
        chk("rst_fire_no_pulse", inputs_ready, 0);
        fire_and_release();
        drained("rst_fire");

        // Reset during WAIT
        align();
        frame4(16'h6161, 16'h6262, 16'h6363, 16'h6464);
        @(negedge clock);
        chk("rst_wait_fire", inputs_ready, 1);
        @(negedge clock);
        align();
        apply_reset("rst_wait");
        fire_and_release();
        drained("rst_wait");

        // Random gaps, mixed frame lengths, random layer latency
        ngood = 0;
        for (int f = 0; f < 20; f++) begin
            lens[f] = ($urandom_range(0, 3) != 0) ? N : $urandom_range(1, 6);
            if (lens[f] == N) ngood++;
        end
        align();
        fork
            stream(20);
            layer_serve(ngood);
        join
        repeat (5) @(negedge clock);
        drained("random");

        // NUM_INPUTS = 1
        send1(16'h1234, 1'b1);
        @(negedge clock);
        chk("n1_fire", n1_inputs_ready, 1);
        chk("n1_value", $unsigned(n1_inputs[0]), 16'h1234);
        chk("n1_fire_no_error", n1_frame_error, 0);
        @(negedge clock);
        chk("n1_pulse_once", n1_inputs_ready, 0);
        chk("n1_wait_busy", n1_busy, 1);
        chk("n1_wait_in_ready", n1_in_ready, 0);
        @(posedge clock);
        #1 n1_outputs_ready = 1'b1;
        @(posedge clock);
        #1 n1_outputs_ready = 1'b0;
        @(negedge clock);
        chk("n1_release", n1_in_ready, 1);
        send1(16'h5555, 1'b0);
        @(negedge clock);
        chk("n1_long_error", n1_frame_error, 1);
        chk("n1_drop_busy", n1_busy, 1);
        chk("n1_long_no_fire", n1_inputs_ready, 0);
        send1(16'h7777, 1'b1);
        @(negedge clock);
        chk("n1_drop_exit_no_fire", n1_inputs_ready, 0);
        chk("n1_drop_exit_busy", n1_busy, 0);
        send1(16'h0ABC, 1'b1);
        @(negedge clock);
        chk("n1_fire2", n1_inputs_ready, 1);
        chk("n1_value2", $unsigned(n1_inputs[0]), 16'h0ABC);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("n1_rst_in_ready", n1_in_ready, 1);
        chk("n1_rst_busy", n1_busy, 0);
        chk("n1_rst_no_fire", n1_inputs_ready, 0);
        chk("n1_rst_value", $unsigned(n1_inputs[0]), 16'h0000);
        send1(16'h0101, 1'b1);
        @(negedge clock);
        chk("n1_fire3", n1_inputs_ready, 1);
        chk("n1_value3", $unsigned(n1_inputs[0]), 16'h0101);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
